// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_ctrl_pkg
// Brief    : State encoding, state enum and elaboration helpers for pll_ctrl.
// Revision : 1.0
// ============================================================================
package pll_ctrl_pkg;

    localparam logic [2:0] c_st_reset_hold = 3'd0;
    localparam logic [2:0] c_st_wait_lock  = 3'd1;
    localparam logic [2:0] c_st_stable     = 3'd2;
    localparam logic [2:0] c_st_run        = 3'd3;
    localparam logic [2:0] c_st_delay_upd  = 3'd4;
    localparam logic [2:0] c_st_fault      = 3'd5;

    typedef enum logic [2:0] {
        RESET_HOLD = c_st_reset_hold,
        WAIT_LOCK  = c_st_wait_lock,
        STABLE     = c_st_stable,
        RUN        = c_st_run,
        DELAY_UPD  = c_st_delay_upd,
        FAULT      = c_st_fault
    } pll_state_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop single-bit synchronizer, cleared by synchronous reset.
// Revision : 1.0
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_ctrl
// Brief    : iCE40 PLL bring-up, lock qualification and dynamic-delay control.
//            Define PLL_CTRL_AUTORESTART_EN to re-run bring-up on lock loss
//            instead of latching FAULT.
// Revision : 1.0
// ============================================================================
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 64,
    parameter int DELAY_SETTLE  = 8,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic [7:0] pll_dynamicdelay,
    input  logic       delay_req,
    input  logic [7:0] delay_val,
    output logic       delay_ack,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retries,
    output logic [2:0] state
);
    localparam int c_cnt_max = max2(max2(LOCK_TIMEOUT, STABLE_CYCLES),
                                    max2(RST_CYCLES, DELAY_SETTLE));
    localparam int c_cnt_w   = (clog2(c_cnt_max) < 1) ? 1 : clog2(c_cnt_max);

    localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last    = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(DELAY_SETTLE - 1);
    localparam logic [1:0]         c_max_retries = 2'(MAX_RETRIES);

`ifdef PLL_CTRL_AUTORESTART_EN
    localparam pll_state_t c_loss_state = RESET_HOLD;
`else
    localparam pll_state_t c_loss_state = FAULT;
`endif

    pll_state_t         r_state,   w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,     w_cnt_nxt,  w_cnt_inc;
    logic [1:0]         r_retries, w_retries_nxt;
    logic [7:0]         r_dly,     w_dly_nxt;
    logic               r_resetb,  w_resetb_nxt;
    logic               r_ack,     w_ack_nxt;
    logic               r_sysrst,  w_sysrst_nxt;
    logic               r_ready,   w_ready_nxt;
    logic               r_fault,   w_fault_nxt;
    logic               w_lock;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pll_lock),
        .o_q (w_lock)
    );

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RESET_HOLD;
            r_cnt     <= '0;
            r_retries <= '0;
            r_dly     <= '0;
            r_resetb  <= 1'b0;
            r_ack     <= 1'b0;
            r_sysrst  <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retries <= w_retries_nxt;
            r_dly     <= w_dly_nxt;
            r_resetb  <= w_resetb_nxt;
            r_ack     <= w_ack_nxt;
            r_sysrst  <= w_sysrst_nxt;
            r_ready   <= w_ready_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_cnt_inc;
        w_retries_nxt = r_retries;
        case (r_state)
            RESET_HOLD: begin
                if (r_cnt == c_rst_last) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (w_lock) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_tmo_last) begin
                    w_retries_nxt = r_retries + 2'd1;
                    w_state_nxt   = (w_retries_nxt == c_max_retries) ? FAULT : RESET_HOLD;
                    w_cnt_nxt     = '0;
                end
            end
            STABLE: begin
                if (!w_lock) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt   = RUN;
                    w_cnt_nxt     = '0;
                    w_retries_nxt = '0;
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
                // A request still high during its own ack cycle is the old one.
                if (!w_lock) begin
                    w_state_nxt = c_loss_state;
                end else if (delay_req && !r_ack) begin
                    w_state_nxt = DELAY_UPD;
                end
            end
            DELAY_UPD: begin
                if (!w_lock) begin
                    w_state_nxt = c_loss_state;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_settle_last) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            end
            FAULT: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = RESET_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_comb begin
        w_resetb_nxt = !((w_state_nxt == RESET_HOLD) || (w_state_nxt == FAULT));
        w_sysrst_nxt = !((w_state_nxt == RUN) || (w_state_nxt == DELAY_UPD));
        w_ready_nxt  = (w_state_nxt == RUN);
        w_fault_nxt  = (w_state_nxt == FAULT);
        w_ack_nxt    = (r_state == DELAY_UPD) && (w_state_nxt == RUN);
        w_dly_nxt    = ((r_state == RUN) && (w_state_nxt == DELAY_UPD)) ? delay_val : r_dly;
    end

    assign pll_resetb       = r_resetb;
    assign pll_bypass       = 1'b0;
    assign pll_dynamicdelay = r_dly;
    assign delay_ack        = r_ack;
    assign sys_rst          = r_sysrst;
    assign ready            = r_ready;
    assign fault            = r_fault;
    assign retries          = r_retries;
    assign state            = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_ctrl
// Brief    : Self-checking bench for pll_ctrl; expected event cycles derived
//            from lock/request timing arithmetic. Honors PLL_CTRL_AUTORESTART_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pll_ctrl;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int DELAY_SETTLE  = 3;
    localparam int MAX_RETRIES   = 2;
    // pll_lock edge to sys_rst release: synchronizer + FSM sample + stability window
    localparam int LOCK_LAT      = 2 + 1 + STABLE_CYCLES;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       delay_req = 1'b0;
    logic [7:0] delay_val = 8'h00;
    logic       pll_resetb, pll_bypass, delay_ack, sys_rst, ready, fault;
    logic [7:0] pll_dynamicdelay;
    logic [1:0] retries;
    logic [2:0] state;

    pll_ctrl #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .DELAY_SETTLE  (DELAY_SETTLE),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pll_lock         (pll_lock),
        .pll_resetb       (pll_resetb),
        .pll_bypass       (pll_bypass),
        .pll_dynamicdelay (pll_dynamicdelay),
        .delay_req        (delay_req),
        .delay_val        (delay_val),
        .delay_ack        (delay_ack),
        .sys_rst          (sys_rst),
        .ready            (ready),
        .fault            (fault),
        .retries          (retries),
        .state            (state)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset(output int r);
        rst = 1'b1; pll_lock = 1'b0; delay_req = 1'b0;
        tick();
        chk("rst_resetb", pll_resetb, 0);
        chk("rst_bypass", pll_bypass, 0);
        chk("rst_dly", pll_dynamicdelay, 0);
        chk("rst_ack", delay_ack, 0);
        chk("rst_sysrst", sys_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_retries", retries, 0);
        tick();
        rst = 1'b0;
        r = cyc;
    endtask

    task automatic bring_up(input int r);
        int t;
        run_to(r + RST_CYCLES - 1);
        chk("bu_hold_low", pll_resetb, 0);
        run_to(r + RST_CYCLES);
        chk("bu_hold_done", pll_resetb, 1);
        t = r + 10 + int'($urandom_range(0, 15));
        run_to(t);
        pll_lock = 1'b1;
        run_to(t + LOCK_LAT - 1);
        chk("bu_sysrst_held", sys_rst, 1);
        chk("bu_ready_low", ready, 0);
        tick();
        chk("bu_sysrst_rel", sys_rst, 0);
        chk("bu_ready", ready, 1);
        chk("bu_retries", retries, 0);
    endtask

    task automatic delay_update(input logic [7:0] v, input bit late_drop);
        delay_val = v;
        delay_req = 1'b1;
        for (int i = 1; i <= DELAY_SETTLE; i++) begin
            tick();
            if (i == 1) chk("du_dly", pll_dynamicdelay, v);
            chk("du_ready_low", ready, 0);
            chk("du_no_ack", delay_ack, 0);
            chk("du_sysrst", sys_rst, 0);
        end
        tick();
        chk("du_ack", delay_ack, 1);
        chk("du_ready_back", ready, 1);
        chk("du_sysrst_end", sys_rst, 0);
        if (!late_drop) delay_req = 1'b0;
        tick();
        chk("du_ack_once", delay_ack, 0);
        chk("du_no_rereq", ready, 1);
        delay_req = 1'b0;
        tick();
        chk("du_idle_ready", ready, 1);
        chk("du_idle_ack", delay_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r, t, q, d, p;
        logic [7:0] v, exp_dly;

        // Normal bring-up and delay updates
        do_reset(r);
        bring_up(r);
        v = 8'h5A;
        delay_update(v, 1'b0);
        exp_dly = v;
        v = 8'($urandom_range(1, 255));
        delay_update(v, 1'b1);
        exp_dly = v;
        chk("dly_kept", pll_dynamicdelay, exp_dly);

        // Lock loss in RUN; new request sampled on the detection edge
        q = cyc;
        pll_lock = 1'b0;
        run_to(q + 2);
        chk("ll_pre_sysrst", sys_rst, 0);
        v = 8'($urandom_range(1, 255));
        if (v == exp_dly) v = ~v;
        delay_val = v;
        delay_req = 1'b1;
        run_to(q + 3);
        chk("ll_sysrst", sys_rst, 1);
        chk("ll_ready", ready, 0);
        chk("ll_ack", delay_ack, 0);
        chk("ll_dly_kept", pll_dynamicdelay, exp_dly);
        chk("ll_resetb", pll_resetb, 0);
`ifdef PLL_CTRL_AUTORESTART_EN
        chk("ll_no_fault", fault, 0);
        chk("ll_retries", retries, 0);
        run_to(q + 5);
        pll_lock = 1'b1;
        run_to(q + 3 + RST_CYCLES - 1);
        chk("ar_hold_low", pll_resetb, 0);
        run_to(q + 3 + RST_CYCLES);
        chk("ar_hold_done", pll_resetb, 1);
        while (cyc < q + 5 + LOCK_LAT - 1) begin
            tick();
            chk("ar_no_ack", delay_ack, 0);
        end
        chk("ar_sysrst_held", sys_rst, 1);
        tick();
        chk("ar_sysrst_rel", sys_rst, 0);
        tick();
        chk("ar_dly", pll_dynamicdelay, v);
        run_to(q + 5 + LOCK_LAT + DELAY_SETTLE);
        chk("ar_ack_wait", delay_ack, 0);
        tick();
        chk("ar_ack", delay_ack, 1);
        delay_req = 1'b0;
`else
        chk("ll_fault", fault, 1);
        pll_lock = 1'b1;
        repeat (6) tick();
        chk("ll_fault_sticky", fault, 1);
        chk("ll_fault_resetb", pll_resetb, 0);
        chk("ll_fault_sysrst", sys_rst, 1);
        chk("ll_fault_no_ack", delay_ack, 0);
        delay_req = 1'b0;
`endif

        // Timeout retries leading to FAULT
        do_reset(r);
        for (int k = 0; k < MAX_RETRIES; k++) begin
            t = r + RST_CYCLES + k * (LOCK_TIMEOUT + RST_CYCLES) + LOCK_TIMEOUT;
            run_to(t - 1);
            chk("to_pre_resetb", pll_resetb, 1);
            chk("to_pre_retries", retries, k);
            run_to(t);
            chk("to_retries", retries, k + 1);
            chk("to_resetb", pll_resetb, 0);
            chk("to_fault", fault, (k + 1 == MAX_RETRIES) ? 1 : 0);
        end
        pll_lock = 1'b1;
        repeat (20) tick();
        chk("to_fault_sticky", fault, 1);
        chk("to_fault_resetb", pll_resetb, 0);
        chk("to_fault_sysrst", sys_rst, 1);

        // Lock glitch in STABLE with a request pending since before RUN
        do_reset(r);
        t = r + 10 + int'($urandom_range(0, 10));
        run_to(t);
        pll_lock = 1'b1;
        v = 8'($urandom_range(1, 255));
        delay_val = v;
        delay_req = 1'b1;
        d = t + 1 + int'($urandom_range(0, STABLE_CYCLES - 1));
        while (cyc < d) begin
            tick();
            chk("gl_no_ack", delay_ack, 0);
        end
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        while (cyc < d + LOCK_LAT) begin
            tick();
            chk("gl_sysrst_held", sys_rst, 1);
            chk("gl_no_ack2", delay_ack, 0);
            chk("gl_retries", retries, 0);
        end
        tick();
        chk("gl_sysrst_rel", sys_rst, 0);
        chk("gl_ready", ready, 1);
        tick();
        chk("gl_dly", pll_dynamicdelay, v);
        repeat (DELAY_SETTLE - 1) begin
            tick();
            chk("gl_ack_wait", delay_ack, 0);
        end
        tick();
        chk("gl_ack", delay_ack, 1);
        delay_req = 1'b0;
        tick();
        chk("gl_ack_once", delay_ack, 0);

        // Reset asserted while a delay update is settling
        p = cyc;
        delay_val = 8'($urandom_range(1, 255));
        delay_req = 1'b1;
        run_to(p + 2);
        chk("rd_settling", ready, 0);
        do_reset(r);
        repeat (DELAY_SETTLE + 3) tick();
        chk("rd_no_ack", delay_ack, 0);
        chk("rd_dly_zero", pll_dynamicdelay, 0);
        chk("rd_sysrst", sys_rst, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
